// File: rtl/fifo_pkg.sv
// Shared helpers for the RAM-backed FIFO: pointer width and scoreboard occupancy type.
package fifo_pkg;

  function automatic int ptr_w(input int words);
    return $clog2(words) + 1;
  endfunction

  typedef int unsigned occ_t;

endpackage

// File: rtl/sdp_ram_fifo_ram.sv
// Simple dual-port RAM: synchronous write on port A, asynchronous read on port B.
// No reset on the array; contents persist across controller resets.
module sdp_ram_ra #(
  parameter int DW    = 8,
  parameter int WORDS = 16,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          wr_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] dout_b
);

  logic [DW-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (wr_a) mem[addr_a] <= din_a;
  end

  assign dout_b = mem[addr_b];

endmodule

// File: rtl/sdp_ram_fifo.sv
// First-word-fall-through FIFO controller over an async-read dual-port RAM.
// Head word visible the cycle after its push; s_ready depends only on stored state, never on m_ready.
module sdp_ram_fifo
  import fifo_pkg::*;
#(
  parameter int DW        = 8,
  parameter int WORDS     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DW-1:0]              s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DW-1:0]              m_data,
  output logic [ptr_w(WORDS)-1:0]    count,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = ptr_w(WORDS);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_TH = PW'(AFULL_TH);
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_TH);

  if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_words
    $error("sdp_ram_fifo: WORDS must be a power of 2 and at least 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > WORDS || AEMPTY_TH < 0 || AEMPTY_TH > WORDS - 1) begin : g_bad_th
    $error("sdp_ram_fifo: threshold out of range");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // Extra MSB distinguishes full from empty when the low address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign s_ready      = !full && rst_n;
  assign m_valid      = !empty;
  assign push         = s_valid && s_ready;
  assign pop          = m_valid && m_ready;
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (s_valid && full)  overflow  <= 1'b1;
      if (m_ready && empty) underflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + PW'(1);
      else if (pop && !push) count <= count - PW'(1);
    end
  end

  sdp_ram_ra #(
    .DW    (DW),
    .WORDS (WORDS)
  ) u_ram (
    .clk    (clk),
    .wr_a   (push),
    .addr_a (wr_ptr[AW-1:0]),
    .din_a  (s_data),
    .addr_b (rd_ptr[AW-1:0]),
    .dout_b (m_data)
  );

endmodule

// File: tb/tb_sdp_ram_fifo.sv
// Directed plan plus random traffic against a queue-based model of the FIFO.
module tb_sdp_ram_fifo;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int WORDS = 4;
  localparam int AFULL_TH = 3;
  localparam int AEMPTY_TH = 1;
  localparam int PW = ptr_w(WORDS);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [PW-1:0] count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf;
  logic          m_unf;

  sdp_ram_fifo #(
    .DW(DW), .WORDS(WORDS), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs with the model, then clock both.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic rn);
    occ_t          n;
    logic [PW-1:0] diff;
    logic          do_push;
    logic          do_pop;
    s_valid = v; s_data = d; m_ready = r; flush = f; rst_n = rn;
    #1;
    n = occ_t'(q.size());
    diff = dut.wr_ptr - dut.rd_ptr;
    chk("s_ready", 32'(s_ready), 32'(rn && n < WORDS));
    chk("m_valid", 32'(m_valid), 32'(n > 0));
    chk("count", 32'(count), n);
    chk("ptr_diff", 32'(diff), n);
    chk("almost_full", 32'(almost_full), 32'(n >= AFULL_TH));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY_TH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    if (n > 0) chk("m_data", 32'(m_data), 32'(q[0]));
    do_push = v && rn && (n < WORDS);
    do_pop  = r && (n > 0);
    @(posedge clk);
    #1;
    if (!rn || f) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (v && n == WORDS) m_ovf = 1'b1;
      if (r && n == 0)     m_unf = 1'b1;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk); #1;
    chk("s_ready_in_reset", 32'(s_ready), 32'h0);
    @(posedge clk); #1;

    // Reset then idle
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);

    // Fill to full, then one extra push attempt
    step(1, 8'h11, 0, 0, 1);
    step(1, 8'h22, 0, 0, 1);
    step(1, 8'h33, 0, 0, 1);
    step(1, 8'h44, 0, 0, 1);
    step(1, 8'h55, 0, 0, 1);
    chk("plan_overflow", 32'(overflow), 32'h1);
    chk("plan_full_count", 32'(count), 32'h4);

    // Drain, then one pop attempt on empty
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 1);
    step(0, 8'h00, 1, 0, 1);
    chk("plan_underflow", 32'(underflow), 32'h1);
    step(0, 8'h00, 0, 0, 1);

    // Streaming through pointer wrap
    for (int i = 0; i < 16; i++) step(1, 8'(i), 1, 0, 1);
    step(0, 8'h00, 1, 0, 1);
    step(0, 8'h00, 0, 0, 1);

    // Flush beats a simultaneous push
    step(1, 8'hA0, 0, 0, 1);
    step(1, 8'hA1, 0, 0, 1);
    step(1, 8'hA2, 0, 1, 1);
    chk("plan_flush_count", 32'(count), 32'h0);
    chk("plan_flush_ovf", 32'(overflow), 32'h0);
    step(1, 8'hB0, 0, 0, 1);
    chk("plan_after_flush_data", 32'(m_data), 32'hB0);
    step(0, 8'h00, 1, 0, 1);

    // Reset mid-stream
    step(1, 8'hC0, 0, 0, 1);
    step(1, 8'hC1, 0, 0, 1);
    step(1, 8'hC2, 0, 0, 0);
    chk("plan_reset_count", 32'(count), 32'h0);
    chk("plan_reset_mvalid", 32'(m_valid), 32'h0);
    step(0, 8'h00, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 99) < 60),
           8'($urandom),
           logic'($urandom_range(0, 99) < 50),
           logic'($urandom_range(0, 99) < 3),
           logic'($urandom_range(0, 99) >= 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdp_ram_fifo.md
Name: sdp_ram_fifo

Overview:
- Synchronous first-word-fall-through FIFO controller built around the team's simple dual-port RAM with asynchronous read (SdpRamRa).
- Sequences the RAM write port from an upstream valid/ready stream and drives the RAM read address from a read pointer.
- The asynchronous read presents the head word combinationally.
- Used as a generic elastic buffer between streaming stages in the memory chapter designs.

Parameters:
- DW, 8, data width in bits.
- WORDS, 16, FIFO depth; must be a power of 2 and at least 2. Elaborate-time assertion otherwise.
- AFULL_TH, 12, almost_full asserts when count >= AFULL_TH (1..WORDS).
- AEMPTY_TH, 4, almost_empty asserts when count <= AEMPTY_TH (0..WORDS-1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of all contents. Same effect as reset, but s_ready stays legal.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  FIFO can accept; push = s_valid & s_ready.
- s_data  in  DW  upstream word.
- m_valid  out  1  head word valid; equals !empty.
- m_ready  in  1  downstream accepts; pop = m_valid & m_ready.
- m_data  out  DW  head word; async RAM read at rd_ptr.
- count  out  $clog2(WORDS)+1  occupancy, 0..WORDS.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- overflow  out  1  sticky: s_valid seen while full. Cleared by reset or flush.
- underflow  out  1  sticky: m_ready seen while empty. Cleared by reset or flush.

Behaviour:
- State: wr_ptr, rd_ptr, each $clog2(WORDS)+1 bits (extra wrap bit); count register; two sticky flags. All are registers updated on posedge clk.
- Reset (rst_n=0 sampled at posedge) clears the following to 0: wr_ptr, rd_ptr, count, overflow, underflow.
- Outputs after reset: m_valid=0, almost_empty=1, almost_full=0, s_ready=1.
- While rst_n is low, s_ready is forced to 0.
- Full and empty are defined from the pointers:
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and wrap bits differ.
- s_ready = !full & rst_n.
  - There is no combinational path from m_ready to s_ready: a pop while full does not enable a same-cycle push.
- Push: the RAM write strobe is wr_a = push, with addr_a = wr_ptr low bits and din_a = s_data. wr_ptr increments, wrapping modulo 2*WORDS.
- Pop: rd_ptr increments. m_data always reflects RAM[rd_ptr low bits]; it is don't-care when m_valid=0.
- Latency: a word pushed at edge N appears on m_data with m_valid=1 after edge N (pushed into an empty FIFO).
  - There is no same-cycle bypass: when empty, m_valid=0 even if s_valid=1.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
  - Push while empty with m_ready=1: pop is 0 because m_valid=0, so count goes to 1.
- count update rules:
  - count += 1 on push-only.
  - count -= 1 on pop-only.
  - Otherwise count holds.
  - Invariant: count == wr_ptr - rd_ptr (mod 2*WORDS), asserted in the bench.
- almost_full and almost_empty are combinational from count.
- Sticky flags set on the cycle after the violating condition and hold until rst_n or flush. The violating access itself has no effect on state.
- Flush has priority over a simultaneous push or pop in the same cycle: the result is empty and the push is dropped.
- Reset has priority over flush.
- Reset mid-stream: contents are discarded logically. RAM contents are not cleared, and there is no reset on the RAM array.

Decomposition:
- Shared package fifo_pkg holds:
  - function ptr_w(words) returning $clog2(words)+1;
  - typedef for the occupancy type used by the bench scoreboard.
- One sub-module: the existing SdpRamRa instance (DW, WORDS) as storage. All control logic stays in sdp_ram_fifo.

Test Plan (DW=8, WORDS=4, AFULL_TH=3, AEMPTY_TH=1):
- Reset then idle -> s_ready=1, m_valid=0, count=0, almost_empty=1, overflow=0, underflow=0.
- Push 0x11,0x22,0x33,0x44 on consecutive cycles, m_ready=0 -> after 4th edge count=4, s_ready=0, almost_full=1. A 5th s_valid=1 (0x55) sets overflow next cycle; count stays 4.
- From full, m_ready=1 for 4 cycles -> m_data sequence 0x11,0x22,0x33,0x44, then m_valid=0, count=0. A further m_ready=1 sets underflow.
- Continuous push and pop of 0x00..0x0F with both valid and ready held high -> ordered output 0x00..0x0F, count toggles 0->1 then stays 1 across pointer wrap (wr_ptr passes 7->0).
- Push 0xA0,0xA1 then flush=1 together with s_valid=1 (0xA2) -> count=0, m_valid=0, flags cleared. Next push 0xB0 gives m_data=0xB0.
- Push 2 words, assert rst_n=0 for 1 cycle with s_valid=1 -> s_ready=0 during reset, count=0 after, m_valid=0.
